decode_ctrl_pipe: RTL
=====================

DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

Interface
REQ-001 SHALL have parameter INSTR_W, default 16, instruction width.
REQ-002 SHALL have parameter PC_W, default 16, PC width.
REQ-003 SHALL have parameter DEPTH, default 4, instruction queue entries (power of two, 2..16).
REQ-004 SHALL have ports, in order:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  block accepts an instruction.
- in_instr  in  INSTR_W  instruction.
- in_pc  in  PC_W  PC+2 of the instruction.
- flush  in  1  discard all queued and staged work.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_instr  out  INSTR_W  staged instruction.
- out_pc  out  PC_W  staged PC+2.
- out_ctrl  out  CTRL_W  packed control bundle (CTRL_W from package).
- halted  out  1  HALT retired to execute.
- err  out  1  sticky trap flag.

Function
REQ-005 SHALL transfer on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready.
REQ-006 SHALL hold instructions in a DEPTH-entry circular FIFO; pointers wrap modulo DEPTH; occupancy counter width is clog2(DEPTH)+1.
REQ-007 SHALL drive in_ready = (count < DEPTH) && state==RUN; simultaneous push and pop when full SHALL NOT be accepted (no same-cycle full bypass).
REQ-008 SHALL decode the FIFO head combinationally and load the output register at the edge where the head exists and (!out_valid || out_ready), popping the head in that cycle.
REQ-009 SHALL have latency exactly 2 cycles from an input handshake to out_valid when empty and out_ready=1, with sustained throughput of 1 per cycle.
REQ-010 SHALL hold out_instr, out_pc and out_ctrl stable while out_valid && !out_ready.
REQ-011 SHALL implement the FSM states RUN, HALTED and TRAP.
- RUN->HALTED: output handshake of a HALT (opcode 00000).
- RUN->TRAP: see REQ-017.
- HALTED and TRAP exit only via reset.
REQ-012 SHALL, in HALTED, assert halted, force in_ready=0 and out_valid=0, and discard FIFO contents.
REQ-013 SHALL, on flush=1, clear the FIFO and out_valid at that edge; flush overrides a same-cycle push and load; flush in HALTED or TRAP has no effect.
REQ-014 SHALL set out_ctrl fields per opcode[15:11] and, for 11011, funct[1:0]; SUB sets Cin and invA; all fields are 0 for NOP.
REQ-015 SHALL drive out_ctrl to all zeros whenever out_valid=0.

Reset
REQ-016 SHALL, with rst_n=0 at a clock edge, set state=RUN, count=0, pointers=0, out_valid=0, out_instr=0, out_pc=0, out_ctrl=0, halted=0 and err=0, overriding flush and any in-flight handshake.

Configuration
REQ-017 SHALL, with DECODE_SIIC_TRAP_EN defined, treat SIIC (00010) and RTI (00011) as traps: at the load edge set err=1, enter TRAP, out_valid=0 and in_ready=0 thereafter.
REQ-018 SHALL, without DECODE_SIIC_TRAP_EN, decode SIIC and RTI as NOP (all ctrl zero, out_valid asserted normally), with err held at 0.

Structure
REQ-019 SHALL take the following from shared package wisc_ctrl_pkg: opcode constants, ctrl field bit offsets, CTRL_W, and FSM state encodings.
REQ-020 SHALL instantiate one combinational sub-module, ctrl_decode (instruction in, packed ctrl out); FIFO, output stage and FSM live in decode_ctrl_pipe.

Verification
REQ-021 SHALL cover ADDI 16'h4125 pushed at cycle 0 with out_ready=1 -> out_valid at cycle 2; ctrl regWrt=1, BSrc=01, wbDataSel=10, regDestSel=01.
REQ-022 SHALL cover 5 pushes with out_ready=0 and DEPTH=4 -> 4 queued plus 1 staged, in_ready=0; out_ready=1 -> 5 bundles in order, one per cycle.
REQ-023 SHALL cover flush asserted with 3 queued and in_valid=1 -> next cycle count=0, out_valid=0, pushed instruction dropped.
REQ-024 SHALL cover HALT 16'h0000 followed by ADDI -> halted=1 after HALT handshake; ADDI never appears; in_ready=0.
REQ-025 SHALL cover SIIC 16'h1000 -> with macro: err=1, no bundle; without macro: bundle with ctrl=0 and err=0.
REQ-026 SHALL cover rst_n=0 for one cycle while full and stalled -> every output at its reset value the next cycle.

Source files
------------

// File: rtl/wisc_ctrl_pkg.sv
// Shared WISC decode definitions: opcodes, control-bundle bit layout and
// pipeline FSM state encodings used by the decode/control stage.
package wisc_ctrl_pkg;

    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_SIIC  = 5'b00010;
    localparam logic [4:0] OP_RTI   = 5'b00011;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_BNEZ  = 5'b01101;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_ALU   = 5'b11011;

    localparam logic [1:0] FN_ADD  = 2'b00;
    localparam logic [1:0] FN_SUB  = 2'b01;
    localparam logic [1:0] FN_XOR  = 2'b10;
    localparam logic [1:0] FN_ANDN = 2'b11;

    // Control bundle bit offsets (2-bit fields start at the given offset).
    localparam int CTRL_REGWRT = 0;
    localparam int CTRL_BSRC   = 1;
    localparam int CTRL_WBSEL  = 3;
    localparam int CTRL_REGDST = 5;
    localparam int CTRL_CIN    = 7;
    localparam int CTRL_INVA   = 8;
    localparam int CTRL_INVB   = 9;
    localparam int CTRL_MEMRD  = 10;
    localparam int CTRL_MEMWR  = 11;
    localparam int CTRL_BRANCH = 12;
    localparam int CTRL_JUMP   = 13;
    localparam int CTRL_HALT   = 14;
    localparam int CTRL_ALUOP  = 15;
    localparam int CTRL_W      = 17;

    localparam logic [1:0] BSRC_REG   = 2'b00;
    localparam logic [1:0] BSRC_IMM5S = 2'b01;
    localparam logic [1:0] BSRC_IMM5Z = 2'b10;
    localparam logic [1:0] BSRC_IMM8S = 2'b11;

    localparam logic [1:0] WB_LINK = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_ALU  = 2'b10;

    localparam logic [1:0] DST_RD42  = 2'b00;
    localparam logic [1:0] DST_RD75  = 2'b01;
    localparam logic [1:0] DST_RD108 = 2'b10;
    localparam logic [1:0] DST_R7    = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_XOR   = 2'b01;
    localparam logic [1:0] ALU_AND   = 2'b10;
    localparam logic [1:0] ALU_PASSB = 2'b11;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        HALTED = 2'b01,
        TRAP   = 2'b10
    } pipeState_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational WISC instruction decoder: opcode (and ALU funct) to the
// packed control bundle. Unknown opcodes, NOP, SIIC and RTI decode to zero.
module ctrl_decode
    import wisc_ctrl_pkg::*;
(
    input  logic [15:0]       instr,
    output logic [CTRL_W-1:0] ctrl
);

    logic [4:0] opcode;
    logic [1:0] funct;
    logic [8:0] unusedBits;

    assign opcode     = instr[15:11];
    assign funct      = instr[1:0];
    assign unusedBits = instr[10:2];

    always_comb begin
        // NOTE: default every field first so no path through the case infers a latch.
        ctrl = '0;
        unique case (opcode)
            OP_HALT: ctrl[CTRL_HALT] = 1'b1;
            OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI: begin
                ctrl[CTRL_REGWRT]       = 1'b1;
                ctrl[CTRL_WBSEL +: 2]   = WB_ALU;
                ctrl[CTRL_REGDST +: 2]  = DST_RD75;
                ctrl[CTRL_BSRC +: 2]    = opcode[1] ? BSRC_IMM5Z : BSRC_IMM5S;
                ctrl[CTRL_ALUOP +: 2]   = (opcode == OP_XORI)  ? ALU_XOR :
                                          (opcode == OP_ANDNI) ? ALU_AND : ALU_ADD;
                ctrl[CTRL_CIN]          = (opcode == OP_SUBI);
                ctrl[CTRL_INVA]         = (opcode == OP_SUBI);
                ctrl[CTRL_INVB]         = (opcode == OP_ANDNI);
            end
            OP_ST: begin
                ctrl[CTRL_MEMWR]        = 1'b1;
                ctrl[CTRL_BSRC +: 2]    = BSRC_IMM5S;
            end
            OP_LD: begin
                ctrl[CTRL_REGWRT]       = 1'b1;
                ctrl[CTRL_MEMRD]        = 1'b1;
                ctrl[CTRL_BSRC +: 2]    = BSRC_IMM5S;
                ctrl[CTRL_WBSEL +: 2]   = WB_MEM;
                ctrl[CTRL_REGDST +: 2]  = DST_RD75;
            end
            OP_LBI: begin
                ctrl[CTRL_REGWRT]       = 1'b1;
                ctrl[CTRL_BSRC +: 2]    = BSRC_IMM8S;
                ctrl[CTRL_ALUOP +: 2]   = ALU_PASSB;
                ctrl[CTRL_WBSEL +: 2]   = WB_ALU;
                ctrl[CTRL_REGDST +: 2]  = DST_RD108;
            end
            OP_BEQZ, OP_BNEZ: ctrl[CTRL_BRANCH] = 1'b1;
            OP_J:   ctrl[CTRL_JUMP] = 1'b1;
            OP_JAL: begin
                ctrl[CTRL_JUMP]         = 1'b1;
                ctrl[CTRL_REGWRT]       = 1'b1;
                ctrl[CTRL_WBSEL +: 2]   = WB_LINK;
                ctrl[CTRL_REGDST +: 2]  = DST_R7;
            end
            OP_ALU: begin
                ctrl[CTRL_REGWRT]       = 1'b1;
                ctrl[CTRL_WBSEL +: 2]   = WB_ALU;
                ctrl[CTRL_REGDST +: 2]  = DST_RD42;
                ctrl[CTRL_ALUOP +: 2]   = (funct == FN_XOR)  ? ALU_XOR :
                                          (funct == FN_ANDN) ? ALU_AND : ALU_ADD;
                ctrl[CTRL_CIN]          = (funct == FN_SUB);
                ctrl[CTRL_INVA]         = (funct == FN_SUB);
                ctrl[CTRL_INVB]         = (funct == FN_ANDN);
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Decode stage: instruction FIFO, registered decoded bundle and RUN/HALTED/TRAP FSM.
// Define DECODE_SIIC_TRAP_EN to make SIIC/RTI trap instead of decoding as NOP.
module decode_ctrl_pipe
    import wisc_ctrl_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 16,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic               halted,
    output logic               err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    pipeState_t         state, nextState;
    logic [PTR_W-1:0]   wrPtr, rdPtr;
    logic [CNT_W-1:0]   count;
    logic [INSTR_W-1:0] instrMem [DEPTH];
    logic [PC_W-1:0]    pcMem [DEPTH];
    logic [INSTR_W-1:0] headInstr;
    logic [CTRL_W-1:0]  headCtrl, ctrlReg;
    logic               validReg, errReg;
    logic               isRun, push, load, retire, haltRetire, trapHead, enterTrap;

    assign isRun      = (state == RUN);
    assign headInstr  = instrMem[rdPtr];
    assign in_ready   = isRun && (count < FULL_CNT);
    assign push       = in_valid && in_ready && !flush;
    assign retire     = validReg && out_ready;
    assign haltRetire = retire && ctrlReg[CTRL_HALT];
    // Nothing new is staged behind a retiring HALT.
    assign load       = isRun && (count != '0) && !flush && (!validReg || out_ready) && !haltRetire;

`ifdef DECODE_SIIC_TRAP_EN
    assign trapHead = (headInstr[15:11] == OP_SIIC) || (headInstr[15:11] == OP_RTI);
`else
    assign trapHead = 1'b0;
`endif
    assign enterTrap = load && trapHead;

    ctrl_decode uDecode (
        .instr (headInstr[15:0]),
        .ctrl  (headCtrl)
    );

    always_comb begin
        nextState = state;
        unique case (state)
            RUN: begin
                if (haltRetire)     nextState = HALTED;
                else if (enterTrap) nextState = TRAP;
            end
            default: nextState = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= nextState;
    end

    // Leaving RUN or flushing discards everything still queued.
    always_ff @(posedge clk) begin
        if (!rst_n || !isRun || flush || haltRetire || enterTrap) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (load) rdPtr <= rdPtr + 1'b1;
            case ({push, load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; count/pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            instrMem[wrPtr] <= in_instr;
            pcMem[wrPtr]    <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            validReg  <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
            ctrlReg   <= '0;
            errReg    <= 1'b0;
        end else begin
            if (enterTrap) errReg <= 1'b1;
            if (load && !trapHead) begin
                validReg  <= 1'b1;
                out_instr <= headInstr;
                out_pc    <= pcMem[rdPtr];
                ctrlReg   <= headCtrl;
            end else if (retire || flush || enterTrap) begin
                validReg  <= 1'b0;
            end
        end
    end

    assign out_valid = validReg;
    assign out_ctrl  = validReg ? ctrlReg : '0;
    assign halted    = (state == HALTED);
    assign err       = errReg;

endmodule
